// File: rtl/nrisc_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | nrisc_pkg : shared constants for the NRISC instruction fetch stage           |
// | Optional feature macro: NRISC_FETCH_PREFETCH_EN (2-entry fetch buffer)       |
// | Revision : 1.0                                                               |
// +-----------------------------------------------------------------------------+
package nrisc_pkg;

  localparam logic [1:0] PC_CTRL_SEQ = 2'd0;
  localparam logic [1:0] PC_CTRL_REL = 2'd1;
  localparam logic [1:0] PC_CTRL_ABS = 2'd2;
  localparam logic [1:0] PC_CTRL_RET = 2'd3;

  typedef enum logic [1:0] {
    FETCH_IDLE  = 2'd0,
    FETCH_REQ   = 2'd1,
    FETCH_FLUSH = 2'd2
  } fetch_state_e;

  localparam logic [15:0] FETCH_RST_VECTOR = 16'h0000;

`ifdef NRISC_FETCH_PREFETCH_EN
  localparam int FETCH_BUF_DEPTH = 2;
`else
  localparam int FETCH_BUF_DEPTH = 1;
`endif

endpackage
`default_nettype wire

// File: rtl/nrisc_instruction_fetch_if.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | nrisc_instruction_fetch_if : instruction-memory req/ack read bus             |
// | Revision : 1.0                                                               |
// +-----------------------------------------------------------------------------+
interface nrisc_instruction_fetch_if #(
  parameter int ADDR_W  = 16,
  parameter int INSTR_W = 16
);
  logic               req;
  logic [ADDR_W-1:0]  addr;
  logic               ack;
  logic [INSTR_W-1:0] rdata;

  modport master (output req, output addr, input ack, input rdata);
  modport slave  (input req, input addr, output ack, output rdata);
endinterface
`default_nettype wire

// File: rtl/nrisc_fetch_buffer.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | nrisc_fetch_buffer : depth-1/2 FIFO of {pc,instr}; head is always entry 0    |
// | Revision : 1.0                                                               |
// +-----------------------------------------------------------------------------+
module nrisc_fetch_buffer #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic [1:0]       count
);

  logic [1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (flush) count_d = 2'd0;
    else       count_d = count_q + {1'b0, push} - {1'b0, pop};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= 2'd0;
    else        count_q <= count_d;
  end

  assign empty = (count_q == 2'd0);
  assign count = count_q;

  if (DEPTH == 2) begin : g_depth2
    logic [WIDTH-1:0] e0_q, e0_d, e1_q, e1_d;

    // A push lands in the head slot when the buffer is, or is about to become, empty.
    always_comb begin
      e0_d = e0_q;
      e1_d = e1_q;
      if (pop) e0_d = e1_q;
      if (push) begin
        if (count_q == 2'd0 || (count_q == 2'd1 && pop)) e0_d = din;
        else                                              e1_d = din;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        e0_q <= '0;
        e1_q <= '0;
      end else begin
        e0_q <= e0_d;
        e1_q <= e1_d;
      end
    end

    assign dout = e0_q;
  end else begin : g_depth1
    logic [WIDTH-1:0] e0_q, e0_d;

    always_comb begin
      e0_d = e0_q;
      if (push) e0_d = din;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) e0_q <= '0;
      else        e0_q <= e0_d;
    end

    assign dout = e0_q;
  end

endmodule
`default_nettype wire

// File: rtl/nrisc_instruction_fetch.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | nrisc_instruction_fetch : PC owner, imem req/ack reader, decoder feed        |
// | Revision : 1.0                                                               |
// +-----------------------------------------------------------------------------+
module nrisc_instruction_fetch
  import nrisc_pkg::*;
#(
  parameter int                ADDR_W     = 16,
  parameter int                INSTR_W    = 16,
  parameter logic [ADDR_W-1:0] RST_VECTOR = ADDR_W'(FETCH_RST_VECTOR)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      stall,
  input  logic                      pc_redirect,
  input  logic [1:0]                pc_ctrl,
  input  logic [ADDR_W-1:0]         pc_target,
  nrisc_instruction_fetch_if.master imem,
  output logic [INSTR_W-1:0]        instr_out,
  output logic [ADDR_W-1:0]         instr_pc,
  output logic                      instr_valid,
  input  logic                      instr_ready,
  output logic [1:0]                fetch_state
);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_fetch_q, pc_fetch_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] last_pc_q, last_pc_d;

  logic                      buf_empty;
  logic [1:0]                buf_count;
  logic [ADDR_W+INSTR_W-1:0] buf_dout;
  logic                      push, pop, redir, space;
  logic [1:0]                cnt_after;
  logic [ADDR_W-1:0]         rel_base, redir_pc;

  assign pop   = instr_valid && instr_ready;
  assign redir = pc_redirect && (pc_ctrl != PC_CTRL_SEQ);
  // A word returned alongside a redirect belongs to the old path and is dropped.
  assign push  = (state_q == FETCH_REQ) && imem.ack && !redir;

  // A word accepted in the same cycle as a relative branch is the branch itself.
  assign rel_base = pop ? instr_pc : last_pc_q;
  assign redir_pc = (pc_ctrl == PC_CTRL_REL) ? rel_base + pc_target : pc_target;

  // Occupancy after this edge; an issued request reserves the slot its word will fill.
  assign cnt_after = redir ? 2'd0 : buf_count + {1'b0, push} - {1'b0, pop};
  assign space     = int'(cnt_after) < FETCH_BUF_DEPTH;

  always_comb begin
    state_d    = state_q;
    pc_fetch_d = pc_fetch_q;
    addr_d     = addr_q;
    last_pc_d  = last_pc_q;
    if (pop)   last_pc_d  = instr_pc;
    if (push)  pc_fetch_d = pc_fetch_q + ADDR_W'(1);
    if (redir) pc_fetch_d = redir_pc;
    case (state_q)
      FETCH_IDLE:  if (!stall && space) state_d = FETCH_REQ;
      FETCH_REQ: begin
        if (imem.ack)   state_d = (!stall && space) ? FETCH_REQ : FETCH_IDLE;
        else if (redir) state_d = FETCH_FLUSH;
      end
      FETCH_FLUSH: if (imem.ack) state_d = (!stall && space) ? FETCH_REQ : FETCH_IDLE;
      default:     state_d = FETCH_IDLE;
    endcase
    // The address only moves when a new request starts, never mid-request.
    if (state_d == FETCH_REQ && (state_q == FETCH_IDLE || imem.ack)) addr_d = pc_fetch_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= FETCH_IDLE;
      pc_fetch_q <= RST_VECTOR;
      addr_q     <= RST_VECTOR;
      last_pc_q  <= RST_VECTOR;
    end else begin
      state_q    <= state_d;
      pc_fetch_q <= pc_fetch_d;
      addr_q     <= addr_d;
      last_pc_q  <= last_pc_d;
    end
  end

  nrisc_fetch_buffer #(
    .WIDTH (ADDR_W + INSTR_W),
    .DEPTH (FETCH_BUF_DEPTH)
  ) u_buf (
    .clk   (clk),
    .rst_n (rst),
    .push  (push),
    .pop   (pop),
    .flush (redir),
    .din   ({addr_q, imem.rdata}),
    .dout  (buf_dout),
    .empty (buf_empty),
    .count (buf_count)
  );

  assign imem.req    = (state_q == FETCH_REQ) || (state_q == FETCH_FLUSH);
  assign imem.addr   = addr_q;
  assign instr_valid = !buf_empty;
  assign instr_out   = buf_dout[INSTR_W-1:0];
  assign instr_pc    = buf_dout[ADDR_W+INSTR_W-1:INSTR_W];
  assign fetch_state = state_q;

endmodule
`default_nettype wire

// File: tb/tb_nrisc_instruction_fetch.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | tb_nrisc_instruction_fetch : directed self-checking bench for fetch stage    |
// | Revision : 1.0                                                               |
// +-----------------------------------------------------------------------------+
module tb_nrisc_instruction_fetch;

  localparam logic [15:0] C_XOR = 16'hA5A5;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall = 1'b0;
  logic        pc_redirect = 1'b0;
  logic [1:0]  pc_ctrl = 2'd0;
  logic [15:0] pc_target = 16'h0000;
  logic [15:0] instr_out;
  logic [15:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready = 1'b1;
  logic [1:0]  fetch_state;

  int checks = 0;
  int failures = 0;

  nrisc_instruction_fetch_if #(.ADDR_W(16), .INSTR_W(16)) imem_if ();

  nrisc_instruction_fetch #(.ADDR_W(16), .INSTR_W(16), .RST_VECTOR(16'h0000)) dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .pc_redirect (pc_redirect),
    .pc_ctrl     (pc_ctrl),
    .pc_target   (pc_target),
    .imem        (imem_if),
    .instr_out   (instr_out),
    .instr_pc    (instr_pc),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .fetch_state (fetch_state)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    imem_if.ack = 1'b0;
    pc_redirect = 1'b0;
    stall = 1'b0;
    instr_ready = 1'b1;
    tick();
    rst = 1'b1;
  endtask

  task automatic wait_req();
    int n = 0;
    while (!imem_if.req && n < 20) begin
      tick();
      n++;
    end
    check_eq("req_seen", imem_if.req, 1);
  endtask

  // Wait for a request, check its address, answer it and optionally check the new head word.
  task automatic serve(input logic [15:0] a, input bit chk_head);
    wait_req();
    check_eq("req_addr", imem_if.addr, a);
    imem_if.ack   = 1'b1;
    imem_if.rdata = a ^ C_XOR;
    tick();
    imem_if.ack = 1'b0;
    if (chk_head) begin
      check_eq("head_valid", instr_valid, 1);
      check_eq("head_pc", instr_pc, a);
      check_eq("head_instr", instr_out, a ^ C_XOR);
    end
  endtask

  initial begin
    imem_if.ack   = 1'b0;
    imem_if.rdata = 16'h0000;
    tick();
    check_eq("rst_req", imem_if.req, 0);
    check_eq("rst_addr", imem_if.addr, 16'h0000);
    check_eq("rst_valid", instr_valid, 0);
    check_eq("rst_instr", instr_out, 0);
    check_eq("rst_pc", instr_pc, 0);
    check_eq("rst_state", fetch_state, 0);

    // Sequential fetch
    rst = 1'b1;
    tick();
    check_eq("t1_state_req", fetch_state, 1);
    serve(16'h0000, 1'b1);
    serve(16'h0001, 1'b1);
    serve(16'h0002, 1'b1);

    // Decoder back-pressure fills the buffer and holds the head stable
    instr_ready = 1'b0;
`ifdef NRISC_FETCH_PREFETCH_EN
    serve(16'h0003, 1'b0);
`endif
    for (int i = 0; i < 5; i++) begin
      tick();
      check_eq("t2_req_off", imem_if.req, 0);
      check_eq("t2_valid", instr_valid, 1);
      check_eq("t2_pc_hold", instr_pc, 16'h0002);
      check_eq("t2_instr_hold", instr_out, 16'h0002 ^ C_XOR);
    end

    // Absolute redirect while a request is outstanding
    do_reset();
    wait_req();
    pc_redirect = 1'b1; pc_ctrl = 2'd2; pc_target = 16'h0040;
    tick();
    pc_redirect = 1'b0;
    check_eq("t3_flush_state", fetch_state, 2);
    check_eq("t3_flush_req", imem_if.req, 1);
    check_eq("t3_flush_addr", imem_if.addr, 16'h0000);
    tick();
    check_eq("t3_addr_stable", imem_if.addr, 16'h0000);
    imem_if.ack = 1'b1; imem_if.rdata = 16'hDEAD;
    tick();
    imem_if.ack = 1'b0;
    check_eq("t3_dropped", instr_valid, 0);
    check_eq("t3_state_req", fetch_state, 1);
    check_eq("t3_new_addr", imem_if.addr, 16'h0040);
    serve(16'h0040, 1'b1);

    // Relative redirect with wrap-around
    do_reset();
    serve(16'h0000, 1'b1);
    serve(16'h0001, 1'b1);
    pc_redirect = 1'b1; pc_ctrl = 2'd1; pc_target = 16'hFFFE;
    tick();
    pc_redirect = 1'b0;
    check_eq("t4_flushed", instr_valid, 0);
    if (fetch_state == 2'd2) begin
      imem_if.ack = 1'b1; imem_if.rdata = 16'hBEEF;
      tick();
      imem_if.ack = 1'b0;
    end
    serve(16'hFFFF, 1'b1);
    serve(16'h0000, 1'b1);

    // Redirect and ack in the same cycle
    do_reset();
    wait_req();
    imem_if.ack = 1'b1; imem_if.rdata = 16'h5555;
    pc_redirect = 1'b1; pc_ctrl = 2'd3; pc_target = 16'h1234;
    tick();
    imem_if.ack = 1'b0; pc_redirect = 1'b0;
    check_eq("t5_no_stale", instr_valid, 0);
    check_eq("t5_state", fetch_state, 1);
    check_eq("t5_req", imem_if.req, 1);
    check_eq("t5_addr", imem_if.addr, 16'h1234);
    serve(16'h1234, 1'b1);

    // Reset during an outstanding request, late ack and stall on restart
    do_reset();
    serve(16'h0000, 1'b1);
    wait_req();
    check_eq("t6_pre_addr", imem_if.addr, 16'h0001);
    rst = 1'b0;
    #1;
    check_eq("t6_req_drop", imem_if.req, 0);
    check_eq("t6_valid_drop", instr_valid, 0);
    check_eq("t6_state_idle", fetch_state, 0);
    check_eq("t6_addr_rst", imem_if.addr, 16'h0000);
    @(negedge clk);
    rst = 1'b1; stall = 1'b1;
    imem_if.ack = 1'b1; imem_if.rdata = 16'h7777;
    tick();
    imem_if.ack = 1'b0;
    check_eq("t6_late_ack", instr_valid, 0);
    check_eq("t6_stall_idle", fetch_state, 0);
    check_eq("t6_stall_noreq", imem_if.req, 0);
    stall = 1'b0;
    tick();
    check_eq("t6_restart_req", imem_if.req, 1);
    check_eq("t6_restart_addr", imem_if.addr, 16'h0000);
    serve(16'h0000, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
